uart_rx_frontend: RTL
=====================

Name: uart_rx_frontend

Overview:
- Receives asynchronous 8N1 serial data from the board `rx` pin and presents each received byte to the core over a valid/ready handshake.
- Sits directly downstream of the pin, in front of the core command logic, in the 100 MHz `clk` domain.
- Handles metastability, start-bit glitch rejection, framing errors and overrun.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- BAUD, 115200, line rate.
- CLKS_PER_BIT, derived (CLK_FREQ_HZ + BAUD/2) / BAUD (868 at defaults), not overridable; elaboration error if < 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- rx  in  1  asynchronous serial line, idle high.
- rx_data  out  8  received byte, stable while rx_valid=1.
- rx_valid  out  1  byte available.
- rx_ready  in  1  consumer accepts; transfer when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while rx_valid still held.
- busy  out  1  FSM not in IDLE/ARM.

Behaviour:
- Reset (synchronous, active-high): every output resets low; rx_data resets to 8'h00; sync flops reset to 1; FSM goes to ARM; counters reset to 0. Reset mid-frame abandons the frame with no pulse.
- Sync: 2-flop synchronizer produces rx_s. Pin-to-rx_s latency is 2 cycles.
- HALF = CLKS_PER_BIT/2, using integer division.
- ARM: wait for rx_s=1, then go to IDLE. This prevents a false start if the line is low at reset release.
- IDLE: on rx_s=0, go to START with bit counter 0 and cycle counter 0.
- START: count HALF cycles, then sample rx_s.
  - rx_s=0: go to DATA with cycle counter cleared.
  - rx_s=1: glitch; go to IDLE with no pulse.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After the 8th sample, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s=1, rx_valid=0 (or rx_valid=1 & rx_ready=1 in this same cycle): next cycle rx_data <= shift register and rx_valid=1; go to IDLE.
  - rx_s=1, rx_valid=1 & rx_ready=0: overrun pulses next cycle; the new byte is dropped and rx_data is unchanged; go to IDLE.
  - rx_s=0: frame_err pulses next cycle; rx_data and rx_valid are unchanged; go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. A held-low line or break yields exactly one frame_err.
- Latency: for a pin falling edge at cycle p, rx_valid (or frame_err/overrun) asserts at cycle p + 3 + HALF + 9*CLKS_PER_BIT.
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1; it drops the next cycle.
  - Simultaneous accept and new-byte completion: the new byte loads and rx_valid stays 1. This is not an overrun.
  - rx_ready has no effect while rx_valid=0.
- Counters:
  - Cycle counter width is $clog2(CLKS_PER_BIT); it clears on every bit boundary and never wraps mid-bit.
  - Bit counter is 3 bits.
- busy is 1 in START/DATA/STOP/BREAK and 0 in ARM/IDLE.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {ARM, IDLE, START, DATA, STOP, BREAK}.
  - Function clks_per_bit(clk_hz, baud).
  - Constant DATA_BITS = 8.
- Sub-module sync_2ff: generic 2-flop synchronizer with reset value parameter. It is reused later for the button inputs.

Test Plan:
(Bench parameters: CLK_FREQ_HZ=16, BAUD=1, so CLKS_PER_BIT=16 and HALF=8.)
1. Frame 0xA5 sent at pin cycle 10, rx_ready=1 -> rx_valid=1 and rx_data=8'hA5 for exactly one cycle at cycle 165; frame_err=0, overrun=0.
2. Two frames 0x3C then 0xC3 with rx_ready=0 throughout -> rx_valid rises with 0x3C and stays; second completion gives an overrun pulse and rx_data stays 0x3C. Then raise rx_ready -> rx_valid falls the next cycle.
3. Frame 0x55 with stop bit driven 0 and the line held low 100 cycles -> exactly one frame_err pulse, no rx_valid; busy stays 1 until the line returns high; the next 0x0F frame is received correctly.
4. 4-cycle low glitch on idle line -> no rx_valid/frame_err, busy returns 0 by cycle glitch+11, the following frame 0x81 is received.
5. Reset asserted mid-DATA of a 0xFF frame while rx is low, released while rx is low -> no output pulses; FSM stays in ARM until rx high; the next frame 0x12 is received.
6. rx_ready pulsed high in the same cycle a second byte 0x77 completes with 0x66 held -> no overrun, rx_data=0x77, rx_valid stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the receiver state encoding, frame geometry and baud arithmetic.
// Imported by the front end and by any later UART blocks (e.g. a transmitter).
package uart_pkg;

    // Payload bits per 8N1 frame.
    localparam int DATA_BITS = 8;

    // Receiver FSM states; ARM and IDLE are the two "not busy" states.
    typedef enum logic [2:0] {
        ARM   = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        BREAK = 3'd5
    } rx_state_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
// Latency: 2 cycles from input to q_o; no handshake, no backpressure.
// Reset value is a parameter so idle-high lines do not glitch out of reset.
module sync_2ff #(
    parameter int                 WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver front end: synchronize pin, deframe bytes, present over valid/ready.
// Latency: byte/error/overrun visible 3 + HALF + 9*CLKS_PER_BIT cycles after the pin start edge.
// Backpressure: one-byte holding register; a byte completing while the previous one is unread is dropped with an overrun pulse.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Bit timing derived from the clock and line rate; not independently settable.
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int CW           = $clog2(CLKS_PER_BIT);

    // Mid-start-bit sample offset and end-of-bit compare value.
    localparam logic [CW-1:0] HALF_C    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CPB_M1    = CW'(CLKS_PER_BIT - 1);
    // Cycles spent in ARM before rx_s is trusted: the synchronizer comes out
    // of reset holding 1s, which would otherwise read as an idle line even
    // when the pin is actually low.
    localparam logic [CW-1:0] ARM_FLUSH = CW'(2);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    // Fewer than 4 clocks per bit leaves no room for mid-bit sampling.
    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx_frontend: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    logic rx_s;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    rx_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;

    // Stop-bit sample point and its two outcomes.
    logic stop_sample;
    logic stop_ok;
    logic stop_bad;

    assign stop_sample = (state_q == STOP) && (cnt_q == CPB_M1);
    assign stop_ok     = stop_sample && rx_s;
    assign stop_bad    = stop_sample && !rx_s;

    // State register plus all datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARM;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic: bit timing, start-glitch rejection and shift-in of data bits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        case (state_q)
            ARM: begin
                // Only leave once the synchronizer holds real pin samples and the line is idle.
                if (cnt_q != ARM_FLUSH) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (rx_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end

            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end

            START: begin
                // Re-check the line near mid start bit; a high here was a glitch.
                if (cnt_q == HALF_C) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                // One sample per bit period, LSB arrives first.
                if (cnt_q == CPB_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : BREAK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            BREAK: begin
                // Hold here through a long low so a break reports only once.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = ARM;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: holding register handshake, overrun and framing-error pulses.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        if (stop_ok) begin
            // A byte accepted this same cycle frees the slot for the new one.
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (stop_bad) begin
            ferr_d = 1'b1;
        end

        busy = (state_q != ARM) && (state_q != IDLE);
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
